voice_alloc: RTL and testbench
==============================

# voice_alloc

Polyphonic voice allocator for the synth, driving a bank of `notebank` voices from note events.
- Accepts key on/off events over a valid/ready handshake and converts each key number to an oscillator period.
- Assigns each note to a voice, issuing one-cycle `note_on`/`note_off` pulses to that voice.
- Tracks every voice until its amplitude envelope reports `done`, which frees the voice.
- Sits between the event source (MIDI parser or keyboard scanner) and the notebank array; runs in the `clk_slow` domain.

## Interface
- `NVOICES`, default 4: number of notebank voices driven (2..8).
- `clk_slow`, in, 1: sole clock. All logic is on its rising edge.
- `rst_b`, in, 1: reset, synchronous and active-low.
- `ev_valid`, in, 1: event present.
- `ev_ready`, out, 1: allocator can accept an event.
- `ev_on`, in, 1: 1 means note-on, 0 means note-off.
- `ev_key`, in, 7: key number, 0..127 (MIDI numbering).
- `note_on`, out, NVOICES: one-cycle start pulse, one bit per voice.
- `note_off`, out, NVOICES: one-cycle release pulse, one bit per voice.
- `period`, out, 32*NVOICES: per-voice oscillator period; voice i occupies bits [32i+31:32i].
- `voice_done`, in, NVOICES: `done` from each voice's amplitude envelope.
- `voice_busy`, out, NVOICES: voice i is not FREE.

## Operation
Per-voice state is FREE, ACTIVE or RELEASING, plus a 7-bit key and an 8-bit saturating age.

Control FSM:
- **IDLE**: `ev_ready`=1. On `ev_valid && ev_ready`, latch `ev_on`/`ev_key` and go to LOOKUP.
- **LOOKUP**: compute the period and select the target voice. Go to ISSUE, or to STEAL if the note-on needs a voice that is ACTIVE.
- **STEAL**: pulse `note_off` on the target voice, then go to ISSUE.
- **ISSUE**: perform the event's pulse and state updates (below), then return to IDLE.

Note-on target selection, first match wins:
1. A non-FREE voice already holding the same key (retrigger). This goes to ISSUE directly, with no STEAL.
2. The lowest-index FREE voice.
3. The oldest RELEASING voice.
4. The oldest ACTIVE voice, via STEAL.

"Oldest" means maximum age; on an age tie, the lowest index wins.

Note-on in ISSUE:
- Pulse `note_on[t]` and load `period[t]`.
- Set the target voice ACTIVE with the event's key, and set its age to 0.
- Increment the age of every other non-FREE voice, saturating at 255.

Note-off in ISSUE:
- Applies to the lowest-index ACTIVE voice whose key matches: pulse `note_off[t]` and set it RELEASING.
- If no ACTIVE voice matches, the event is consumed with no pulse and no state change.

Freeing voices:
- Any RELEASING voice with `voice_done[i]`=1 becomes FREE on that edge.
- An ACTIVE voice ignores `voice_done`.
- If `voice_done[i]`=1 on the same edge that ISSUE targets voice i, the ISSUE update wins.

Period arithmetic:
- `oct` = `ev_key`/12 and `n` = `ev_key`%12.
- `period` = `NOTE_TOP[n] >> oct`, where `NOTE_TOP` holds the 32-bit periods for octave 0.
- `period` holds its value until the next note-on to that voice.

Reset (`rst_b`=0 at an edge): all voices FREE, key 0, age 0, `period` 0, `note_on`/`note_off` 0, `voice_busy` 0, FSM in IDLE. `ev_ready` is 0 while `rst_b` is low and 1 in the first cycle after release. Reset mid-operation abandons the latched event, and no pulse is issued afterward.

## Timing
Let the handshake occur at edge 0.
- LOOKUP occupies cycle 1.
- Without a steal: `note_on` and the new `period` are high/visible in cycle 2. `ev_ready` returns in cycle 3. Throughput is one event per 3 cycles.
- With a steal: `note_off[t]` is high in cycle 2, `note_on[t]` in cycle 3, and `ev_ready` returns in cycle 4.
- `note_on`/`note_off` are registered and never high for more than one cycle.
- At most one voice pulses per cycle.
- `voice_busy` updates on the same edge as the state change it reflects.
- `ev_key`/`ev_on` need only be valid at the handshake edge.

## Structure
- Package `synth_pkg` holds:
  - `NOTE_TOP[0:11]`, the octave-0 period constants, with `NOTE_TOP[9]` = 32'd2048000 (A, the 440-Hz reference in octave 5).
  - The voice-state encoding (FREE=2'd0, ACTIVE=2'd1, RELEASING=2'd2).
  - The FSM state encoding.
- One sub-module, `key_period`: combinational conversion of the 7-bit key to the 32-bit period (divide/mod by 12, table lookup, shift).
- The voice table and FSM live in `voice_alloc`.

## Test plan
- **Basic note-on:** reset, then note-on key 69 → `note_on`=4'b0001 in cycle 2, `period[31:0]`=64000, `voice_busy`=4'b0001, `ev_ready` high in cycle 3.
- **Fill and steal:** note-on keys 60, 62, 64, 65, then 67 with no releases → the fifth event gives `note_off[0]` in cycle 2 and `note_on[0]` in cycle 3, voice 0 now holds key 67, and `ev_ready` returns in cycle 4.
- **Release and done:** note-on 60, note-off 60 → `note_off[0]` pulse and voice RELEASING. Drive `voice_done[0]`=1 for one cycle → `voice_busy[0]`=0 the next cycle.
- **Retrigger:** note-on 60, note-off 60, then note-on 60 before done → `note_on[0]` again, no `note_off` pulse, voice 0 ACTIVE, `voice_busy`=4'b0001.
- **Stray note-off:** note-off key 50 with no matching voice → no pulses, state unchanged, `ev_ready` back in cycle 3.
- **Reset mid-event:** assert `rst_b`=0 in cycle 1 after a note-on handshake → no `note_on` pulse, all outputs 0, `ev_ready`=1 in the first cycle after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and encodings for the synth voice allocator.
// Holds the octave-0 period table plus voice/FSM state encodings.
// No logic; imported by voice_alloc and key_period.
package synth_pkg;

  // Octave-0 oscillator periods, C..B; A (index 9) is 2048000 so key 69 gives 64000.
  localparam logic [31:0] NOTE_TOP [0:11] = '{
    32'd3444312, 32'd3250997, 32'd3068533, 32'd2896309,
    32'd2733752, 32'd2580318, 32'd2435496, 32'd2298802,
    32'd2169780, 32'd2048000, 32'd1933057, 32'd1824560
  };

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_ACTIVE    = 2'd1,
    V_RELEASING = 2'd2
  } vstate_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_STEAL  = 2'd2,
    S_ISSUE  = 2'd3
  } fsm_t;

endpackage

// File: rtl/key_period.sv
// Converts a 7-bit key number to its 32-bit oscillator period.
// Purely combinational, zero latency.
// No handshake; output follows input.
module key_period
  import synth_pkg::*;
(
  input  logic [6:0]  i_key,
  output logic [31:0] o_period
);

  logic [3:0] w_oct;
  logic [3:0] w_n;

  // Each octave up halves the period, so shift the octave-0 entry right.
  assign w_oct    = 4'(i_key / 7'd12);
  assign w_n      = 4'(i_key % 7'd12);
  assign o_period = NOTE_TOP[w_n] >> w_oct;

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps key on/off events onto NVOICES notebank voices.
// Latency: pulse 2 cycles after handshake (3 when a voice is stolen); ready again 1 cycle later.
// Backpressure: ev_ready is low from handshake until the event has fully issued.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NVOICES = 4
)
(
  input  logic                   clk_slow,
  input  logic                   rst_b,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic                   ev_on,
  input  logic [6:0]             ev_key,
  output logic [NVOICES-1:0]     note_on,
  output logic [NVOICES-1:0]     note_off,
  output logic [32*NVOICES-1:0]  period,
  input  logic [NVOICES-1:0]     voice_done,
  output logic [NVOICES-1:0]     voice_busy
);

  localparam int IW = $clog2(NVOICES);

  fsm_t               r_state;
  fsm_t               w_next;
  logic               r_ev_on;
  logic [6:0]         r_ev_key;
  logic [IW-1:0]      r_tgt;
  vstate_t            r_vs     [NVOICES];
  logic [6:0]         r_vkey   [NVOICES];
  logic [7:0]         r_age    [NVOICES];
  logic [31:0]        r_period [NVOICES];
  logic [NVOICES-1:0] r_note_on;
  logic [NVOICES-1:0] r_note_off;

  logic [31:0]        w_period;
  logic [IW-1:0]      w_tgt;
  logic               w_need_steal;
  logic               w_off_hit;
  logic               w_ready;
  logic               w_do_steal;
  logic               w_do_issue;
  logic [IW-1:0]      w_issue_tgt;

  key_period u_key_period (
    .i_key    (r_ev_key),
    .o_period (w_period)
  );

  // Target selection from the latched event: retrigger, free, oldest releasing, oldest active.
  always_comb begin
    logic          hit_same, hit_free, hit_rel, hit_act, hit_off;
    logic [IW-1:0] w_same_idx, w_free_idx, w_rel_idx, w_act_idx, w_off_idx;
    logic [7:0]    w_rel_age, w_act_age;
    hit_same = 1'b0; hit_free = 1'b0; hit_rel = 1'b0; hit_act = 1'b0; hit_off = 1'b0;
    w_same_idx = '0; w_free_idx = '0; w_rel_idx = '0; w_act_idx = '0; w_off_idx = '0;
    w_rel_age = '0; w_act_age = '0;
    for (int i = 0; i < NVOICES; i++) begin
      if (r_vs[i] != V_FREE && r_vkey[i] == r_ev_key && !hit_same) begin
        hit_same = 1'b1; w_same_idx = IW'(i);
      end
      if (r_vs[i] == V_FREE && !hit_free) begin
        hit_free = 1'b1; w_free_idx = IW'(i);
      end
      // Strict '>' keeps the lowest index on an age tie.
      if (r_vs[i] == V_RELEASING && (!hit_rel || r_age[i] > w_rel_age)) begin
        hit_rel = 1'b1; w_rel_idx = IW'(i); w_rel_age = r_age[i];
      end
      if (r_vs[i] == V_ACTIVE && (!hit_act || r_age[i] > w_act_age)) begin
        hit_act = 1'b1; w_act_idx = IW'(i); w_act_age = r_age[i];
      end
      if (r_vs[i] == V_ACTIVE && r_vkey[i] == r_ev_key && !hit_off) begin
        hit_off = 1'b1; w_off_idx = IW'(i);
      end
    end
    w_tgt        = '0;
    w_need_steal = 1'b0;
    w_off_hit    = hit_off;
    if (!r_ev_on)     w_tgt = w_off_idx;
    else if (hit_same) w_tgt = w_same_idx;
    else if (hit_free) w_tgt = w_free_idx;
    else if (hit_rel)  w_tgt = w_rel_idx;
    else begin
      w_tgt        = w_act_idx;
      w_need_steal = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_slow) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ev_valid && w_ready) w_next = S_LOOKUP;
      S_LOOKUP: w_next = (r_ev_on && w_need_steal) ? S_STEAL : S_ISSUE;
      S_STEAL:  w_next = S_ISSUE;
      S_ISSUE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs; pulses are registered on the edge entering STEAL/ISSUE so they show in that cycle.
  always_comb begin
    w_ready     = rst_b && (r_state == S_IDLE);
    w_do_steal  = (r_state == S_LOOKUP) && r_ev_on && w_need_steal;
    w_do_issue  = ((r_state == S_LOOKUP) && !(r_ev_on && w_need_steal)) || (r_state == S_STEAL);
    w_issue_tgt = (r_state == S_STEAL) ? r_tgt : w_tgt;
  end

  // Latch the event at the handshake and the chosen voice at the end of LOOKUP.
  always_ff @(posedge clk_slow) begin
    if (!rst_b) begin
      r_ev_on  <= 1'b0;
      r_ev_key <= '0;
      r_tgt    <= '0;
    end else begin
      if (ev_valid && w_ready) begin
        r_ev_on  <= ev_on;
        r_ev_key <= ev_key;
      end
      if (r_state == S_LOOKUP) r_tgt <= w_tgt;
    end
  end

  // Voice table: frees on done, then the issue update overrides its target voice.
  always_ff @(posedge clk_slow) begin
    if (!rst_b) begin
      r_note_on  <= '0;
      r_note_off <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        r_vs[i]     <= V_FREE;
        r_vkey[i]   <= '0;
        r_age[i]    <= '0;
        r_period[i] <= '0;
      end
    end else begin
      r_note_on  <= '0;
      r_note_off <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        if (r_vs[i] == V_RELEASING && voice_done[i]) r_vs[i] <= V_FREE;
      end
      if (w_do_steal) r_note_off[w_tgt] <= 1'b1;
      if (w_do_issue) begin
        if (r_ev_on) begin
          for (int i = 0; i < NVOICES; i++) begin
            if (IW'(i) != w_issue_tgt && r_vs[i] != V_FREE && r_age[i] != 8'hFF)
              r_age[i] <= r_age[i] + 8'd1;
          end
          r_note_on[w_issue_tgt] <= 1'b1;
          r_period[w_issue_tgt]  <= w_period;
          r_vs[w_issue_tgt]      <= V_ACTIVE;
          r_vkey[w_issue_tgt]    <= r_ev_key;
          r_age[w_issue_tgt]     <= '0;
        end else if (w_off_hit) begin
          r_note_off[w_issue_tgt] <= 1'b1;
          r_vs[w_issue_tgt]       <= V_RELEASING;
        end
      end
    end
  end

  assign ev_ready = w_ready;
  assign note_on  = r_note_on;
  assign note_off = r_note_off;

  for (genvar g = 0; g < NVOICES; g++) begin : g_out
    assign period[32*g +: 32] = r_period[g];
    assign voice_busy[g]      = (r_vs[g] != V_FREE);
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: vector table, hand sequences, randomized model run.
module tb_voice_alloc;

  localparam int NV = 4;

  logic              clk_slow = 1'b0;
  logic              rst_b;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [6:0]        ev_key;
  logic [NV-1:0]     note_on;
  logic [NV-1:0]     note_off;
  logic [32*NV-1:0]  period;
  logic [NV-1:0]     voice_done;
  logic [NV-1:0]     voice_busy;

  int checks = 0;
  int errors = 0;

  voice_alloc #(.NVOICES(NV)) dut (
    .clk_slow   (clk_slow),
    .rst_b      (rst_b),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_key     (ev_key),
    .note_on    (note_on),
    .note_off   (note_off),
    .period     (period),
    .voice_done (voice_done),
    .voice_busy (voice_busy)
  );

  always #5 clk_slow = ~clk_slow;

  // Equal-tempered octave-0 periods, A = 2048000.
  logic [31:0] TB_TOP [12] = '{
    32'd3444312, 32'd3250997, 32'd3068533, 32'd2896309,
    32'd2733752, 32'd2580318, 32'd2435496, 32'd2298802,
    32'd2169780, 32'd2048000, 32'd1933057, 32'd1824560
  };

  function automatic logic [31:0] tb_period(input int key);
    return TB_TOP[key % 12] >> (key / 12);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (event timeline over a voice list) -------------
  int            m_st  [NV];   // 0 free, 1 active, 2 releasing
  int            m_key [NV];
  int            m_age [NV];
  logic [31:0]   m_per [NV];
  logic [NV-1:0] m_on, m_off;
  bit            m_inflight;
  int            m_phase;
  bit            m_steal;
  int            m_tgt;
  bit            m_evon;
  int            m_evkey;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = 0; m_key[i] = 0; m_age[i] = 0; m_per[i] = '0;
    end
    m_on = '0; m_off = '0; m_inflight = 0; m_phase = 0; m_steal = 0; m_tgt = -1;
  endfunction

  function automatic void model_select();
    int best;
    m_steal = 0; m_tgt = -1;
    if (!m_evon) begin
      for (int i = NV - 1; i >= 0; i--) if (m_st[i] == 1 && m_key[i] == m_evkey) m_tgt = i;
      return;
    end
    for (int i = NV - 1; i >= 0; i--) if (m_st[i] != 0 && m_key[i] == m_evkey) m_tgt = i;
    if (m_tgt >= 0) return;
    for (int i = NV - 1; i >= 0; i--) if (m_st[i] == 0) m_tgt = i;
    if (m_tgt >= 0) return;
    best = -1;
    for (int i = 0; i < NV; i++) if (m_st[i] == 2 && (best < 0 || m_age[i] > m_age[best])) best = i;
    if (best >= 0) begin m_tgt = best; return; end
    for (int i = 0; i < NV; i++) if (m_st[i] == 1 && (best < 0 || m_age[i] > m_age[best])) best = i;
    m_tgt = best; m_steal = 1;
  endfunction

  function automatic void model_edge(input bit hs, input bit on, input int key, input logic [NV-1:0] d);
    bit issue = 0;
    m_on = '0; m_off = '0;
    if (m_inflight) begin
      m_phase++;
      if (m_steal) begin
        if (m_phase == 1) m_off[m_tgt] = 1'b1;
        if (m_phase == 2) issue = 1;
        if (m_phase == 3) m_inflight = 0;
      end else begin
        if (m_phase == 1) issue = 1;
        if (m_phase == 2) m_inflight = 0;
      end
    end
    if (issue && m_evon)
      for (int i = 0; i < NV; i++)
        if (i != m_tgt && m_st[i] != 0 && m_age[i] < 255) m_age[i]++;
    for (int i = 0; i < NV; i++) if (m_st[i] == 2 && d[i]) m_st[i] = 0;
    if (issue) begin
      if (m_evon) begin
        m_on[m_tgt] = 1'b1; m_st[m_tgt] = 1; m_key[m_tgt] = m_evkey;
        m_age[m_tgt] = 0; m_per[m_tgt] = tb_period(m_evkey);
      end else if (m_tgt >= 0) begin
        m_off[m_tgt] = 1'b1; m_st[m_tgt] = 2;
      end
    end
    if (hs) begin
      m_evon = on; m_evkey = key; model_select(); m_inflight = 1; m_phase = 0;
    end
  endfunction

  task automatic compare_model();
    logic [32*NV-1:0] ep;
    logic [NV-1:0]    eb;
    for (int i = 0; i < NV; i++) begin
      ep[32*i +: 32] = m_per[i];
      eb[i] = (m_st[i] != 0);
    end
    chk("m_note_on",  128'(note_on),    128'(m_on));
    chk("m_note_off", 128'(note_off),   128'(m_off));
    chk("m_busy",     128'(voice_busy), 128'(eb));
    chk("m_period",   128'(period),     128'(ep));
    chk("m_ready",    128'(ev_ready),   128'(rst_b && !m_inflight));
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 after it.
  task automatic cycle(input logic v, input logic on, input logic [6:0] key, input logic [NV-1:0] d);
    bit hs;
    ev_valid = v; ev_on = on; ev_key = key; voice_done = d;
    hs = v && rst_b && !m_inflight;
    @(posedge clk_slow);
    if (!rst_b) model_reset();
    else        model_edge(hs, on, int'(key), d);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    cycle(1'b0, 1'b0, 7'd0, '0);
    cycle(1'b0, 1'b0, 7'd0, '0);
    rst_b = 1'b1;
  endtask

  logic [NV-1:0] h_on  [1:4];
  logic [NV-1:0] h_off [1:4];
  logic          h_rdy [1:4];

  // Handshake one event, then record pulses/ready for cycles 1..4.
  task automatic send(input logic on, input logic [6:0] key);
    int w = 0;
    while (ev_ready !== 1'b1 && w < 10) begin
      cycle(1'b0, 1'b0, 7'd0, '0);
      w++;
    end
    chk("ready_wait", 128'(ev_ready), 128'(1'b1));
    cycle(1'b1, on, key, '0);
    h_on[1] = note_on; h_off[1] = note_off; h_rdy[1] = ev_ready;
    for (int k = 2; k <= 4; k++) begin
      cycle(1'b0, 1'b0, 7'd0, '0);
      h_on[k] = note_on; h_off[k] = note_off; h_rdy[k] = ev_ready;
    end
  endtask

  typedef struct packed {
    logic          on;
    logic [6:0]    key;
    logic          steal;
    int            tgt;
    logic [NV-1:0] busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV-1:0] e_on2, e_off2, e_on3;
    int            t;
    logic          rv, ro;
    logic [6:0]    rk;
    logic [NV-1:0] rd;

    tbl[0] = '{1'b1, 7'd60, 1'b0,  0, 4'b0001};
    tbl[1] = '{1'b1, 7'd62, 1'b0,  1, 4'b0011};
    tbl[2] = '{1'b1, 7'd64, 1'b0,  2, 4'b0111};
    tbl[3] = '{1'b1, 7'd65, 1'b0,  3, 4'b1111};
    tbl[4] = '{1'b1, 7'd67, 1'b1,  0, 4'b1111};
    tbl[5] = '{1'b0, 7'd62, 1'b0,  1, 4'b1111};
    tbl[6] = '{1'b1, 7'd70, 1'b0,  1, 4'b1111};
    tbl[7] = '{1'b0, 7'd50, 1'b0, -1, 4'b1111};
    tbl[8] = '{1'b1, 7'd67, 1'b0,  0, 4'b1111};
    tbl[9] = '{1'b1, 7'd72, 1'b1,  2, 4'b1111};

    ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0; voice_done = '0;
    model_reset();

    // Reset state and basic note-on.
    do_reset();
    chk("rst_busy",   128'(voice_busy), 128'(4'b0000));
    chk("rst_period", 128'(period),     128'(0));
    chk("rst_pulses", 128'({note_on, note_off}), 128'(0));
    cycle(1'b0, 1'b0, 7'd0, '0);
    chk("rst_ready_after", 128'(ev_ready), 128'(1'b1));
    send(1'b1, 7'd69);
    chk("basic_on2",    128'(h_on[2]),       128'(4'b0001));
    chk("basic_period", 128'(period[31:0]),  128'(32'd64000));
    chk("basic_busy",   128'(voice_busy),    128'(4'b0001));
    chk("basic_rdy2",   128'(h_rdy[2]),      128'(1'b0));
    chk("basic_rdy3",   128'(h_rdy[3]),      128'(1'b1));

    // Vector table: fill, steal, release, stray note-off, retrigger, steal oldest.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      send(tbl[v].on, tbl[v].key);
      e_on2 = '0; e_off2 = '0; e_on3 = '0;
      t = tbl[v].tgt;
      if (tbl[v].steal) begin
        e_off2[t] = 1'b1; e_on3[t] = 1'b1;
      end else if (t >= 0) begin
        if (tbl[v].on) e_on2[t] = 1'b1;
        else           e_off2[t] = 1'b1;
      end
      chk($sformatf("v%0d_c1", v),  128'({h_on[1], h_off[1], h_rdy[1]}), 128'(0));
      chk($sformatf("v%0d_on2", v), 128'(h_on[2]),  128'(e_on2));
      chk($sformatf("v%0d_off2", v), 128'(h_off[2]), 128'(e_off2));
      chk($sformatf("v%0d_on3", v), 128'(h_on[3]),  128'(e_on3));
      chk($sformatf("v%0d_off3", v), 128'(h_off[3]), 128'(0));
      chk($sformatf("v%0d_rdy2", v), 128'(h_rdy[2]), 128'(1'b0));
      chk($sformatf("v%0d_rdy3", v), 128'(h_rdy[3]), 128'(!tbl[v].steal));
      chk($sformatf("v%0d_rdy4", v), 128'(h_rdy[4]), 128'(1'b1));
      chk($sformatf("v%0d_busy", v), 128'(voice_busy), 128'(tbl[v].busy));
      if (tbl[v].on)
        chk($sformatf("v%0d_period", v), 128'(period[32*t +: 32]), 128'(tb_period(int'(tbl[v].key))));
    end

    // Release, done, retrigger before done.
    do_reset();
    send(1'b1, 7'd60);
    cycle(1'b0, 1'b0, 7'd0, 4'b0001);
    chk("active_ignores_done", 128'(voice_busy), 128'(4'b0001));
    send(1'b0, 7'd60);
    chk("rel_off2", 128'(h_off[2]), 128'(4'b0001));
    chk("rel_busy", 128'(voice_busy), 128'(4'b0001));
    send(1'b1, 7'd60);
    chk("retrig_on2",  128'(h_on[2]),  128'(4'b0001));
    chk("retrig_offs", 128'({h_off[2], h_off[3]}), 128'(0));
    chk("retrig_busy", 128'(voice_busy), 128'(4'b0001));
    send(1'b0, 7'd60);
    cycle(1'b0, 1'b0, 7'd0, 4'b0001);
    chk("done_frees", 128'(voice_busy), 128'(4'b0000));

    // Reset during LOOKUP abandons the event.
    do_reset();
    cycle(1'b0, 1'b0, 7'd0, '0);
    cycle(1'b1, 1'b1, 7'd60, '0);
    rst_b = 1'b0;
    cycle(1'b0, 1'b0, 7'd0, '0);
    chk("midrst_outs",  128'({note_on, note_off, voice_busy, ev_ready}), 128'(0));
    rst_b = 1'b1;
    cycle(1'b0, 1'b0, 7'd0, '0);
    chk("midrst_ready", 128'(ev_ready), 128'(1'b1));
    chk("midrst_noon",  128'({note_on, voice_busy}), 128'(0));
    cycle(1'b0, 1'b0, 7'd0, '0);
    chk("midrst_noon2", 128'({note_on, note_off}), 128'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rv = ($urandom_range(0, 1) == 1);
      ro = ($urandom_range(0, 9) < 6);
      rk = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(58, 63));
      rd = NV'($urandom) & NV'($urandom);
      cycle(rv, ro, rk, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
